// File: rtl/inequality_sweep_checker.sv
// On-chip sweep checker for a 4-bit Inequality comparator: drives NUM through 0..15,
// waits SETTLE cycles per value, then scores the {lt,eq,gt} result against THRESH.
module inequality_sweep_checker #(
  parameter int unsigned THRESH = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [2:0] out_i,
  output logic [3:0] num_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [4:0] fail_cnt_o,
  output logic       first_fail_valid_o,
  output logic [3:0] first_fail_num_o
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      num_q, num_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [4:0]      fail_cnt_q, fail_cnt_d;
  logic            ff_valid_q, ff_valid_d;
  logic [3:0]      ff_num_q, ff_num_d;

  logic [2:0]      expected;
  logic            mismatch;

  // Any pattern other than the exact one-hot answer counts as a miss, including 000/111.
  assign expected = {num_q < 4'(THRESH), num_q == 4'(THRESH), num_q > 4'(THRESH)};
  assign mismatch = (out_i != expected);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_cnt_d = fail_cnt_q;
    ff_valid_d = ff_valid_q;
    ff_num_d   = ff_num_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_d      = 4'd0;
          fail_cnt_d = 5'd0;
          ff_valid_d = 1'b0;
          ff_num_d   = 4'd0;
          pass_d     = 1'b0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          fail_cnt_d = fail_cnt_q + 5'd1;
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_num_d   = num_q;
          end
        end
        // DONE is registered, so it is raised on the edge that enters FINISH.
        if (num_q == 4'd15) begin
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          num_d   = num_q + 4'd1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end

      S_FINISH: begin
        pass_d  = (fail_cnt_q == 5'd0);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      num_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= 5'd0;
      ff_valid_q <= 1'b0;
      ff_num_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_cnt_q <= fail_cnt_d;
      ff_valid_q <= ff_valid_d;
      ff_num_q   <= ff_num_d;
    end
  end

  assign num_o              = num_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;
  assign fail_cnt_o         = fail_cnt_q;
  assign first_fail_valid_o = ff_valid_q;
  assign first_fail_num_o   = ff_num_q;

endmodule

// File: tb/tb_inequality_sweep_checker.sv
// Bench for inequality_sweep_checker: a behavioural comparator with selectable faults
// feeds the checker; sweep results are compared against hand-computed expectations.
module tb_inequality_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start1;
  logic [2:0] outA, outB;
  int         mode;

  logic [3:0] numA, numB, ffNumA, ffNumB;
  logic       busyA, busyB, doneA, doneB, passA, passB, ffValidA, ffValidB;
  logic [4:0] failA, failB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inequality_sweep_checker #(.THRESH(8), .SETTLE(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .out_i(outA),
    .num_o(numA), .busy_o(busyA), .done_o(doneA), .pass_o(passA),
    .fail_cnt_o(failA), .first_fail_valid_o(ffValidA), .first_fail_num_o(ffNumA)
  );

  inequality_sweep_checker #(.THRESH(8), .SETTLE(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .out_i(outB),
    .num_o(numB), .busy_o(busyB), .done_o(doneB), .pass_o(passB),
    .fail_cnt_o(failB), .first_fail_valid_o(ffValidB), .first_fail_num_o(ffNumB)
  );

  // Comparator under test, with fault modes: 0 good, 1 stuck 100, 2 stuck 000,
  // 3 stuck 111, 4 multi-hot at NUM=3, 5 eq instead of gt at NUM=15.
  function automatic logic [2:0] compOut(input logic [3:0] n, input int m);
    logic [2:0] good;
    good = {n < 4'd8, n == 4'd8, n > 4'd8};
    case (m)
      1:       return 3'b100;
      2:       return 3'b000;
      3:       return 3'b111;
      4:       return (n == 4'd3) ? 3'b110 : good;
      5:       return (n == 4'd15) ? 3'b010 : good;
      default: return good;
    endcase
  endfunction

  assign outA = compOut(numA, mode);
  assign outB = compOut(numB, 0);

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts a sweep on dut and counts edges from START acceptance to DONE.
  task automatic applyStimulus(input int pulseAt, input bit checkNum, output int edges);
    bit pulsed;
    int expNum;
    pulsed = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    edges = 0;
    checkOutput("start_busy", busyA, 1);
    checkOutput("start_pass_clr", passA, 0);
    checkOutput("start_fail_clr", failA, 0);
    while (edges < 200) begin
      if (pulseAt >= 0 && !pulsed && numA == 4'(pulseAt)) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (checkNum) begin
        expNum = (edges / 3 > 15) ? 15 : edges / 3;
        checkOutput($sformatf("num_e%0d", edges), numA, expNum);
        checkOutput($sformatf("busy_e%0d", edges), busyA, 1);
      end
      if (doneA) break;
    end
    start = 1'b0;
  endtask

  typedef struct {
    int mode;
    int pulseAt;
    int expFail;
    int expValid;
    int expFirst;
    int expPass;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int edges;
    int doneSeen;
    int waitCnt;

    vecs[0] = '{0, -1, 0,  0, 0,  1};
    vecs[1] = '{1, -1, 8,  1, 8,  0};
    vecs[2] = '{2, -1, 16, 1, 0,  0};
    vecs[3] = '{3, -1, 16, 1, 0,  0};
    vecs[4] = '{4, -1, 1,  1, 3,  0};
    vecs[5] = '{5, -1, 1,  1, 15, 0};
    vecs[6] = '{0, 5,  0,  0, 0,  1};

    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_num", numA, 0);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_done", doneA, 0);
    checkOutput("rst_pass", passA, 0);
    checkOutput("rst_fail", failA, 0);
    checkOutput("rst_ffv", ffValidA, 0);
    checkOutput("rst_ffn", ffNumA, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      mode = vecs[i].mode;
      applyStimulus(vecs[i].pulseAt, i == 0, edges);
      checkOutput($sformatf("v%0d_done_edge", i), edges, 48);
      checkOutput($sformatf("v%0d_done", i), doneA, 1);
      checkOutput($sformatf("v%0d_busy_fin", i), busyA, 1);
      checkOutput($sformatf("v%0d_failcnt", i), failA, vecs[i].expFail);
      checkOutput($sformatf("v%0d_ffvalid", i), ffValidA, vecs[i].expValid);
      checkOutput($sformatf("v%0d_ffnum", i), ffNumA, vecs[i].expFirst);
      @(posedge clk); @(negedge clk);
      checkOutput($sformatf("v%0d_done_low", i), doneA, 0);
      checkOutput($sformatf("v%0d_busy_low", i), busyA, 0);
      checkOutput($sformatf("v%0d_pass", i), passA, vecs[i].expPass);
      repeat (2) @(negedge clk);
    end

    // Asynchronous reset in the middle of a sweep while NUM=9.
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    waitCnt = 0;
    while (numA != 4'd9 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("rst_reach_num9", numA, 9);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_num", numA, 0);
    checkOutput("arst_busy", busyA, 0);
    checkOutput("arst_done", doneA, 0);
    checkOutput("arst_pass", passA, 0);
    checkOutput("arst_fail", failA, 0);
    checkOutput("arst_ffv", ffValidA, 0);
    checkOutput("arst_ffn", ffNumA, 0);
    @(negedge clk); rst_n = 1'b1;
    doneSeen = 0;
    repeat (60) begin
      @(negedge clk);
      if (doneA || busyA) doneSeen++;
    end
    checkOutput("arst_no_done", doneSeen, 0);
    checkOutput("arst_idle_num", numA, 0);
    applyStimulus(-1, 1'b0, edges);
    checkOutput("post_rst_done_edge", edges, 48);
    @(posedge clk); @(negedge clk);
    checkOutput("post_rst_pass", passA, 1);

    // SETTLE=1 with START held high: back-to-back sweeps.
    @(negedge clk); start1 = 1'b1;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (doneB) break;
    end
    checkOutput("s1_done_edge", edges, 32);
    checkOutput("s1_busy_fin", busyB, 1);
    checkOutput("s1_failcnt", failB, 0);
    @(posedge clk); @(negedge clk);
    checkOutput("s1_done_low", doneB, 0);
    checkOutput("s1_busy_low", busyB, 0);
    checkOutput("s1_pass_held", passB, 1);
    checkOutput("s1_num_hold", numB, 15);
    @(posedge clk); @(negedge clk);
    checkOutput("s1_restart_busy", busyB, 1);
    checkOutput("s1_restart_num", numB, 0);
    checkOutput("s1_restart_pass", passB, 0);
    start1 = 1'b0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
